sram_controller_pmu_req: RTL and testbench

PMU-side initiator for the SRAM power-state handshake. It accepts sleep and wake commands from the PMU and drives the level requests `pwr_save_req` and `pwr_restore_req`. It holds each request until the controller FSM's `fsm_state` reports the target state, then releases it, enforces a timeout, and reports completion or error. It sits in the PMU clock domain, and its request outputs feed the controller's request synchronizer.

---
 rtl/sram_controller_pmu_req.sv | 151 +++++++++++++++
 tb/tb_sram_controller_pmu_req.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller_pmu_req.sv
// PMU-side initiator for the SRAM power-state handshake (sleep/wake requests).
// Ports: clk, reset_n (async low); cmd_valid/cmd_op/cmd_ready command channel;
//   fsm_state (controller state), bus_active; pwr_save_req/pwr_restore_req
//   level requests; busy, done, err_timeout pulses, err_sticky/err_clr.
// Optional macro SRAM_PMU_AUTO_SLEEP_EN adds an idle counter that issues an
//   internal sleep command after IDLE_CYCLES idle bus cycles.
module sram_controller_pmu_req #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16,
   parameter int IDLE_CYCLES    = 4096
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   input  logic       cmd_op,
   output logic       cmd_ready,
   input  logic [1:0] fsm_state,
   input  logic       bus_active,
   output logic       pwr_save_req,
   output logic       pwr_restore_req,
   output logic       busy,
   output logic       done,
   output logic       err_timeout,
   output logic       err_sticky,
   input  logic       err_clr
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_SAVE = 2'b01;
   localparam logic [1:0] S_REST = 2'b10;
   localparam logic [1:0] S_REL  = 2'b11;

   localparam logic [1:0] FS_ACTIVE = 2'b00;
   localparam logic [1:0] FS_SLEEP  = 2'b01;
   localparam logic [1:0] FS_BAD    = 2'b11;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nx;
   logic             r_done;
   logic             r_err;
   logic             r_sticky;
   logic             w_done_nx;
   logic             w_err_nx;
   logic             w_go;
   logic             w_op;
   logic             w_auto;
   logic [1:0]       w_target;

`ifdef SRAM_PMU_AUTO_SLEEP_EN
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

   logic [CNT_W-1:0] r_idle_cnt;
   logic             w_idle_ok;

   // An external command in the same cycle wins and restarts the count.
   assign w_idle_ok = (r_state == S_IDLE) && (fsm_state == FS_ACTIVE) &&
                      !bus_active && !cmd_valid;
   assign w_auto    = w_idle_ok && (r_idle_cnt == IDLE_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idle_cnt <= '0;
      end else if (!w_idle_ok || w_auto) begin
         r_idle_cnt <= '0;
      end else begin
         r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      end
   end
`else
   logic w_unused;

   assign w_auto   = 1'b0;
   assign w_unused = bus_active ^ (IDLE_CYCLES == 0);
`endif

   assign w_go     = (r_state == S_IDLE) && (cmd_valid || w_auto);
   assign w_op     = cmd_valid ? cmd_op : 1'b1;
   assign w_target = (r_state == S_SAVE) ? FS_SLEEP : FS_ACTIVE;

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_done_nx  = 1'b0;
      w_err_nx   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_go) begin
               w_cnt_nx = '0;
               // Already in the requested state: complete without a request.
               if (w_op ? (fsm_state == FS_SLEEP) : (fsm_state == FS_ACTIVE)) begin
                  w_state_nx = S_REL;
                  w_done_nx  = 1'b1;
               end else begin
                  w_state_nx = w_op ? S_SAVE : S_REST;
               end
            end
         end
         S_SAVE, S_REST: begin
            if (fsm_state == FS_BAD) begin
               w_state_nx = S_REL;
               w_err_nx   = 1'b1;
            end else if (fsm_state == w_target) begin
               w_state_nx = S_REL;
               w_done_nx  = 1'b1;
            end else if (r_cnt == TMO_LAST) begin
               w_state_nx = S_REL;
               w_err_nx   = 1'b1;
            end else if (r_cnt != '1) begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_done  <= w_done_nx;
         r_err   <= w_err_nx;
         // A new abort beats a simultaneous clear.
         if (w_err_nx) begin
            r_sticky <= 1'b1;
         end else if (err_clr) begin
            r_sticky <= 1'b0;
         end
      end
   end

   assign pwr_save_req    = (r_state == S_SAVE);
   assign pwr_restore_req = (r_state == S_REST);
   assign busy            = (r_state != S_IDLE);
   assign cmd_ready       = (r_state == S_IDLE);
   assign done            = r_done;
   assign err_timeout     = r_err;
   assign err_sticky      = r_sticky;

endmodule

// File: tb/tb_sram_controller_pmu_req.sv
// Bench for sram_controller_pmu_req: two instances (long and short timeout)
// checked against a transaction-level model, a vector table and sequences.
module tb_sram_controller_pmu_req;

   localparam int TA  = 32;
   localparam int TB  = 8;
   localparam int IDL = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       v;
   logic       op;
   logic       clr;
   logic       bus;
   logic [1:0] fs;

   logic rdy[2];
   logic save[2];
   logic rest[2];
   logic busy_o[2];
   logic done_o[2];
   logic err_o[2];
   logic stk[2];

   always #5 clk = ~clk;

   sram_controller_pmu_req #(
      .TIMEOUT_CYCLES(TA), .CNT_W(16), .IDLE_CYCLES(IDL)
   ) u_a (
      .clk(clk), .reset_n(reset_n), .cmd_valid(v), .cmd_op(op),
      .cmd_ready(rdy[0]), .fsm_state(fs), .bus_active(bus),
      .pwr_save_req(save[0]), .pwr_restore_req(rest[0]), .busy(busy_o[0]),
      .done(done_o[0]), .err_timeout(err_o[0]), .err_sticky(stk[0]),
      .err_clr(clr)
   );

   sram_controller_pmu_req #(
      .TIMEOUT_CYCLES(TB), .CNT_W(16), .IDLE_CYCLES(IDL)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .cmd_valid(v), .cmd_op(op),
      .cmd_ready(rdy[1]), .fsm_state(fs), .bus_active(bus),
      .pwr_save_req(save[1]), .pwr_restore_req(rest[1]), .busy(busy_o[1]),
      .done(done_o[1]), .err_timeout(err_o[1]), .err_sticky(stk[1]),
      .err_clr(clr)
   );

   int errors = 0;
   int checks = 0;

   // Model: which request is held (0 none, 1 save, 2 restore), for how
   // many cycles, whether the one-cycle release is in progress.
   int m_req[2];
   int m_held[2];
   int m_idle[2];
   bit m_rel[2];
   bit m_done[2];
   bit m_err[2];
   bit m_stk[2];

   int gap[2];
   bit prev[2];
   bit started[2];

   typedef struct {
      logic       v;
      logic       op;
      logic       clr;
      logic [1:0] fs;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(logic v_, logic o_, logic c_, int f_, logic [6:0] e_);
      vec_t r;
      r.v   = v_;
      r.op  = o_;
      r.clr = c_;
      r.fs  = 2'(f_);
      r.exp = e_;
      return r;
   endfunction

   function automatic int tmo(int i);
      return (i == 0) ? TA : TB;
   endfunction

   function automatic logic [6:0] act_vec(int i);
      return {save[i], rest[i], busy_o[i], rdy[i], done_o[i], err_o[i], stk[i]};
   endfunction

   function automatic logic [6:0] exp_vec(int i);
      bit b;
      b = (m_req[i] != 0) || m_rel[i];
      return {m_req[i] == 1, m_req[i] == 2, b, !b, m_done[i], m_err[i], m_stk[i]};
   endfunction

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_req[i]  = 0;
         m_held[i] = 0;
         m_idle[i] = 0;
         m_rel[i]  = 1'b0;
         m_done[i] = 1'b0;
         m_err[i]  = 1'b0;
         m_stk[i]  = 1'b0;
         gap[i]     = 0;
         prev[i]    = 1'b0;
         started[i] = 1'b0;
      end
   endtask

   task automatic model_accept(int i, bit o);
      if ((o && fs == 2'b01) || (!o && fs == 2'b00)) begin
         m_rel[i]  = 1'b1;
         m_done[i] = 1'b1;
      end else begin
         m_req[i]  = o ? 1 : 2;
         m_held[i] = 1;
      end
   endtask

   task automatic model_abort(int i);
      m_req[i] = 0;
      m_rel[i] = 1'b1;
      m_err[i] = 1'b1;
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit idle_now;
         bit fire;
         int tgt;
         idle_now  = (m_req[i] == 0) && !m_rel[i];
         fire      = 1'b0;
         m_done[i] = 1'b0;
         m_err[i]  = 1'b0;
`ifdef SRAM_PMU_AUTO_SLEEP_EN
         if (idle_now && !v && !bus && fs == 2'b00) begin
            if (m_idle[i] == IDL - 1) begin
               fire      = 1'b1;
               m_idle[i] = 0;
            end else begin
               m_idle[i]++;
            end
         end else begin
            m_idle[i] = 0;
         end
`endif
         if (m_rel[i]) begin
            m_rel[i] = 1'b0;
         end else if (idle_now) begin
            if (v) model_accept(i, op);
            else if (fire) model_accept(i, 1'b1);
         end else begin
            tgt = (m_req[i] == 1) ? 1 : 0;
            if (fs == 2'b11) begin
               model_abort(i);
            end else if (int'(fs) == tgt) begin
               m_req[i]  = 0;
               m_rel[i]  = 1'b1;
               m_done[i] = 1'b1;
            end else if (m_held[i] == tmo(i)) begin
               model_abort(i);
            end else begin
               m_held[i]++;
            end
         end
         if (m_err[i]) m_stk[i] = 1'b1;
         else if (clr) m_stk[i] = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         bit lvl;
         chk((i == 0) ? "model_a" : "model_b", int'(act_vec(i)), int'(exp_vec(i)));
         lvl = save[i] || rest[i];
         if (lvl && !prev[i] && started[i]) begin
            chk("req_gap", int'(gap[i] >= 2), 1);
         end
         if (lvl) begin
            gap[i]     = 0;
            started[i] = 1'b1;
         end else begin
            gap[i]++;
         end
         prev[i] = lvl;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int held;
      int dn;
      int sh;
      int er;
      v       = 1'b0;
      op      = 1'b0;
      clr     = 1'b0;
      bus     = 1'b1;
      fs      = 2'b00;
      reset_n = 1'b0;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         chk("reset_state", int'(act_vec(i)), int'(7'b0001000));
      end

      // {save,rest,busy,ready,done,err,sticky} for the long-timeout unit.
      tbl[0]  = mk(1'b1, 1'b1, 1'b0, 0, 7'b1010000);
      tbl[1]  = mk(1'b0, 1'b0, 1'b0, 0, 7'b1010000);
      tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1, 7'b0010100);
      tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1, 7'b0001000);
      tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1, 7'b0010100);
      tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1, 7'b0001000);
      tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1, 7'b0110000);
      tbl[7]  = mk(1'b0, 1'b0, 1'b0, 3, 7'b0010011);
      tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1, 7'b0001001);
      tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1, 7'b0001000);
      tbl[10] = mk(1'b1, 1'b0, 1'b0, 0, 7'b0010100);
      tbl[11] = mk(1'b0, 1'b0, 1'b0, 0, 7'b0001000);
      tbl[12] = mk(1'b1, 1'b0, 1'b0, 2, 7'b0110000);
      tbl[13] = mk(1'b0, 1'b0, 1'b0, 2, 7'b0110000);
      tbl[14] = mk(1'b0, 1'b0, 1'b0, 0, 7'b0010100);
      tbl[15] = mk(1'b0, 1'b0, 1'b0, 0, 7'b0001000);
      tbl[16] = mk(1'b1, 1'b1, 1'b0, 0, 7'b1010000);
      tbl[17] = mk(1'b0, 1'b0, 1'b1, 3, 7'b0010011);
      tbl[18] = mk(1'b0, 1'b0, 1'b0, 0, 7'b0001001);
      tbl[19] = mk(1'b0, 1'b0, 1'b1, 0, 7'b0001000);
      for (int k = 0; k < 20; k++) begin
         v   = tbl[k].v;
         op  = tbl[k].op;
         clr = tbl[k].clr;
         fs  = tbl[k].fs;
         step();
         chk($sformatf("vec%0d", k), int'(act_vec(0)), int'(tbl[k].exp));
      end
      v   = 1'b0;
      clr = 1'b0;

      // Sleep handshake.
      fs = 2'b00;
      v  = 1'b1;
      op = 1'b1;
      step();
      chk("t1_req_c1", int'(save[0]), 1);
      v = 1'b0;
      repeat (3) begin
         step();
         chk("t1_req_hold", int'(save[0]), 1);
      end
      fs = 2'b01;
      step();
      chk("t1_done", int'({save[0], done_o[0], rdy[0]}), int'(3'b010));
      step();
      chk("t1_ready", int'(rdy[0]), 1);

      // Wake through a long WAKEUP phase.
      v  = 1'b1;
      op = 1'b0;
      step();
      chk("t2_req", int'(rest[0]), 1);
      v    = 1'b0;
      fs   = 2'b10;
      held = 0;
      dn   = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (rest[0]) held++;
         if (done_o[0]) dn++;
      end
      chk("t2_held", held, 20);
      fs = 2'b00;
      repeat (2) begin
         step();
         if (done_o[0]) dn++;
      end
      chk("t2_done", dn, 1);
      chk("t2_sticky", int'(stk[0]), 0);

      // Timeout on the short-timeout unit.
      clr = 1'b1;
      step();
      clr = 1'b0;
      v   = 1'b1;
      op  = 1'b1;
      step();
      v  = 1'b0;
      sh = save[1] ? 1 : 0;
      er = 0;
      dn = 0;
      for (int k = 0; k < 15; k++) begin
         step();
         if (save[1]) sh++;
         if (err_o[1]) er++;
         if (done_o[1]) dn++;
      end
      chk("t3_held", sh, TB);
      chk("t3_err", er, 1);
      chk("t3_nodone", dn, 0);
      chk("t3_sticky", int'(stk[1]), 1);
      fs = 2'b01;
      repeat (2) step();
      clr = 1'b1;
      step();
      chk("t3_clr", int'(stk[1]), 0);
      clr = 1'b0;

      // Asynchronous reset in the middle of a save request.
      fs = 2'b00;
      v  = 1'b1;
      op = 1'b1;
      step();
      v = 1'b0;
      step();
      chk("t5_pre", int'(save[0]), 1);
      #2;
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("t5_async", int'(act_vec(i)), int'(7'b0001000));
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Random traffic with alternating ops held on cmd_valid.
      for (int c = 0; c < 2000; c++) begin
         int r;
         v = ($urandom_range(0, 3) != 0);
         if (v) op = ~op;
         r = int'($urandom_range(0, 99));
         if (r < 10) fs = 2'($urandom_range(0, 2));
         else if (r < 11) fs = 2'b11;
         clr = ($urandom_range(0, 15) == 0);
`ifdef SRAM_PMU_AUTO_SLEEP_EN
         bus = ($urandom_range(0, 15) != 0);
`else
         bus = ($urandom_range(0, 1) != 0);
`endif
         step();
      end
      v   = 1'b0;
      clr = 1'b0;
      bus = 1'b1;
      fs  = 2'b01;
      repeat (3) step();

      // Long-timeout unit stuck in ACTIVE.
      fs = 2'b00;
      v  = 1'b1;
      op = 1'b1;
      step();
      v = 1'b0;
      repeat (40) step();

`ifdef SRAM_PMU_AUTO_SLEEP_EN
      clr = 1'b1;
      step();
      clr = 1'b0;
      bus = 1'b0;
      sh  = 0;
      for (int k = 0; k < IDL - 1; k++) begin
         step();
         if (save[0]) sh++;
      end
      chk("t6_early", sh, 0);
      step();
      chk("t6_auto", int'(save[0]), 1);
      fs  = 2'b01;
      bus = 1'b1;
      repeat (2) step();
      fs = 2'b00;
      step();
      bus = 1'b0;
      repeat (10) step();
      bus = 1'b1;
      step();
      bus = 1'b0;
      sh  = 0;
      for (int k = 0; k < IDL - 1; k++) begin
         step();
         if (save[0]) sh++;
      end
      chk("t6_restart", sh, 0);
      step();
      chk("t6_auto2", int'(save[0]), 1);
      fs  = 2'b01;
      bus = 1'b1;
      repeat (2) step();
`else
      bus = 1'b0;
      sh  = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (save[0] || save[1]) sh++;
      end
      chk("no_auto", sh, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
